// File: rtl/genius_datapath_param.sv
// Genius (Simon) game datapath: LFSR colour sequence, LED playback, key checking, per-press timeout.
// Defining GENIUS_BEST_SCORE_EN adds the 'best' output (highest completed round since reset).
module genius_datapath_param #(
    parameter int unsigned P_COLORS  = 4,
    parameter int unsigned P_LEVELS  = 16,
    parameter int unsigned P_SHOW    = 25_000_000,
    parameter int unsigned P_GAP     = 12_500_000,
    parameter int unsigned P_TIMEOUT = 250_000_000,
    parameter logic [15:0] P_SEED    = 16'hACE1,
    localparam int unsigned RW       = $clog2(P_LEVELS + 1)
) (
    input  logic                CLOCK_50,
    input  logic                R,
    input  logic                START,
    input  logic [P_COLORS-1:0] KEY,
    output logic [P_COLORS-1:0] leds,
    output logic [RW-1:0]       round,
    output logic                end_FPGA,
    output logic                end_User,
    output logic                end_time,
    output logic                match,
    output logic                win,
    output logic                over,
    output logic                busy
`ifdef GENIUS_BEST_SCORE_EN
    ,
    output logic [RW-1:0]       best
`endif
);

    localparam int unsigned CW    = (P_COLORS > 1) ? $clog2(P_COLORS) : 1;
    localparam int unsigned IW    = $clog2(P_LEVELS);
    localparam int unsigned T_SG  = (P_SHOW > P_GAP) ? P_SHOW : P_GAP;
    localparam int unsigned T_MAX = (P_TIMEOUT > T_SG) ? P_TIMEOUT : T_SG;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_USER, S_WIN, S_LOSE
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [P_COLORS-1:0]   key_s1_q, key_s2_q, key_prev_q;
    logic [P_COLORS-1:0]   fell;
    logic                  evt_q, evt_d;
    logic                  evt_clean_q, evt_clean_d;
    logic [P_COLORS-1:0]   evt_bits_q, evt_bits_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [RW-1:0]         round_q, round_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [P_COLORS-1:0]   leds_q, leds_d;
    logic                  end_fpga_q, end_fpga_d;
    logic                  end_user_q, end_user_d;
    logic                  end_time_q, end_time_d;
    logic                  match_q, match_d;
    logic                  win_q, win_d;
    logic                  over_q, over_d;
    logic                  busy_q, busy_d;
    logic                  seq_we;
    logic [CW-1:0]         seq_q [P_LEVELS];
    logic [P_COLORS-1:0]   exp_key;
    logic                  last_entry;

    function automatic logic [P_COLORS-1:0] onehot(input logic [CW-1:0] c);
        logic [P_COLORS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11; free-running so the sequence depends on START timing
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Falling edges of the synchronised keys; several at once or on top of a held key is a bad press
    always_comb begin
        fell        = key_prev_q & ~key_s2_q;
        evt_d       = |fell;
        evt_bits_d  = fell;
        evt_clean_d = ((fell & (fell - P_COLORS'(1))) == '0) && ((~key_s2_q & ~fell) == '0);
    end

    assign exp_key    = onehot(seq_q[idx_q]);
    assign last_entry = (RW'(idx_q) + RW'(1)) == round_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        round_d    = round_q;
        tmr_d      = tmr_q;
        end_fpga_d = 1'b0;
        end_user_d = 1'b0;
        end_time_d = 1'b0;
        match_d    = 1'b0;
        seq_we     = 1'b0;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (START) begin
                    state_d = S_LOAD;
                    round_d = RW'(1);
                    idx_d   = '0;
                    tmr_d   = '0;
                end
            end
            S_LOAD: begin
                seq_we = 1'b1;
                if (idx_q == IW'(P_LEVELS - 1)) begin
                    state_d = S_SHOW_ON;
                    idx_d   = '0;
                    tmr_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_SHOW_ON: begin
                if (tmr_q == TW'(P_SHOW - 1)) begin
                    state_d = S_SHOW_OFF;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_SHOW_OFF: begin
                if (tmr_q == TW'(P_GAP - 1)) begin
                    tmr_d = '0;
                    if (last_entry) begin
                        end_fpga_d = 1'b1;
                        idx_d      = '0;
                        state_d    = S_WAIT_USER;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WAIT_USER: begin
                // a press takes priority over a timeout in the same cycle
                if (evt_q) begin
                    if (evt_clean_q && (evt_bits_q == exp_key)) begin
                        match_d = 1'b1;
                        tmr_d   = '0;
                        if (last_entry) begin
                            end_user_d = 1'b1;
                            idx_d      = '0;
                            if (round_q == RW'(P_LEVELS)) begin
                                state_d = S_WIN;
                            end else begin
                                round_d = round_q + RW'(1);
                                state_d = S_SHOW_ON;
                            end
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        state_d = S_LOSE;
                    end
                end else if (tmr_q == TW'(P_TIMEOUT - 1)) begin
                    end_time_d = 1'b1;
                    state_d    = S_LOSE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the state being entered
        leds_d = '0;
        case (state_d)
            S_SHOW_ON:   leds_d = onehot(seq_q[idx_d]);
            S_WAIT_USER: leds_d = ~key_s2_q;
            S_WIN:       leds_d = '1;
            default:     leds_d = '0;
        endcase
        win_d  = (state_d == S_WIN);
        over_d = (state_d == S_LOSE);
        busy_d = !((state_d == S_IDLE) || (state_d == S_WIN) || (state_d == S_LOSE));
    end

    always_ff @(posedge CLOCK_50 or posedge R) begin
        if (R) begin
            state_q     <= S_IDLE;
            lfsr_q      <= P_SEED;
            key_s1_q    <= '1;
            key_s2_q    <= '1;
            key_prev_q  <= '1;
            evt_q       <= 1'b0;
            evt_clean_q <= 1'b0;
            evt_bits_q  <= '0;
            idx_q       <= '0;
            round_q     <= '0;
            tmr_q       <= '0;
            leds_q      <= '0;
            end_fpga_q  <= 1'b0;
            end_user_q  <= 1'b0;
            end_time_q  <= 1'b0;
            match_q     <= 1'b0;
            win_q       <= 1'b0;
            over_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            key_s1_q    <= KEY;
            key_s2_q    <= key_s1_q;
            key_prev_q  <= key_s2_q;
            evt_q       <= evt_d;
            evt_clean_q <= evt_clean_d;
            evt_bits_q  <= evt_bits_d;
            idx_q       <= idx_d;
            round_q     <= round_d;
            tmr_q       <= tmr_d;
            leds_q      <= leds_d;
            end_fpga_q  <= end_fpga_d;
            end_user_q  <= end_user_d;
            end_time_q  <= end_time_d;
            match_q     <= match_d;
            win_q       <= win_d;
            over_q      <= over_d;
            busy_q      <= busy_d;
        end
    end

    // Sequence storage needs no reset; LOAD rewrites every entry
    always_ff @(posedge CLOCK_50) begin
        if (seq_we) begin
            seq_q[idx_q] <= lfsr_q[CW-1:0];
        end
    end

`ifdef GENIUS_BEST_SCORE_EN
    logic [RW-1:0] best_q, best_d;

    always_comb begin
        best_d = best_q;
        if (end_user_d && (round_q > best_q)) begin
            best_d = round_q;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge R) begin
        if (R) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best = best_q;
`endif

    assign leds     = leds_q;
    assign round    = round_q;
    assign end_FPGA = end_fpga_q;
    assign end_User = end_user_q;
    assign end_time = end_time_q;
    assign match    = match_q;
    assign win      = win_q;
    assign over     = over_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_genius_datapath_param.sv
// Self-checking bench for genius_datapath_param: random START timing and press delays,
// expected colour sequence from a free-running LFSR model sampled during LOAD.
module tb_genius_datapath_param;

    localparam int unsigned NC   = 4;
    localparam int unsigned NL   = 4;
    localparam int unsigned NS   = 4;
    localparam int unsigned NG   = 2;
    localparam int unsigned NT   = 20;
    localparam int unsigned RW   = $clog2(NL + 1);
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NC-1:0] key;
    logic [NC-1:0] leds;
    logic [RW-1:0] round;
    logic          end_fpga, end_user, end_time, match, win, over, busy;
`ifdef GENIUS_BEST_SCORE_EN
    logic [RW-1:0] best;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int n_match     = 0;
    int exp_seq [NL];
    logic [15:0] m_lfsr;

    genius_datapath_param #(
        .P_COLORS(NC), .P_LEVELS(NL), .P_SHOW(NS), .P_GAP(NG), .P_TIMEOUT(NT), .P_SEED(SEED)
    ) dut (
        .CLOCK_50(clk), .R(rst), .START(start), .KEY(key), .leds(leds), .round(round),
        .end_FPGA(end_fpga), .end_User(end_user), .end_time(end_time), .match(match),
        .win(win), .over(over), .busy(busy)
`ifdef GENIUS_BEST_SCORE_EN
        , .best(best)
`endif
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, stepping once per clock out of reset
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic int oh2i(input logic [NC-1:0] v);
        for (int i = 0; i < int'(NC); i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle a random number of cycles, pulse START, record the colours written during LOAD
    task automatic do_start(input int idle);
        repeat (idle) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(NL); i++) begin
            exp_seq[i] = int'(m_lfsr[1:0]);
            @(negedge clk);
        end
    endtask

    // Record the lit colours until end_FPGA, then compare with the first r model entries
    task automatic playback(input int r);
        int seen [$];
        logic [NC-1:0] prev;
        int budget;
        prev   = '0;
        budget = 0;
        while (!end_fpga && budget < 400) begin
            if (leds != '0 && prev == '0) seen.push_back(oh2i(leds));
            prev = leds;
            @(negedge clk);
            budget++;
        end
        check("end_FPGA arrives", 32'(end_fpga), 32'd1);
        check("playback length", 32'(seen.size()), 32'(r));
        for (int i = 0; i < r && i < seen.size(); i++)
            check("playback colour", 32'(seen[i]), 32'(exp_seq[i]));
    endtask

    // One-cycle-low KEY pulse; returns on the third negedge after the sampling edge
    task automatic press(input logic [NC-1:0] mask);
        key = ~mask;
        @(negedge clk);
        key = '1;
        @(negedge clk);
        check("match not before edge 3 (a)", 32'(match), 32'd0);
        @(negedge clk);
        check("match not before edge 3 (b)", 32'(match), 32'd0);
        @(negedge clk);
    endtask

    task automatic play_round(input int r);
        logic [NC-1:0] m;
        playback(r);
        check("round during play", 32'(round), 32'(r));
        for (int i = 0; i < r; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            m = '0;
            m[exp_seq[i]] = 1'b1;
            press(m);
            check("match on correct press", 32'(match), 32'd1);
            if (match) n_match++;
            check("end_User on last press", 32'(end_user), 32'(i == r - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, w, early;
        logic [NC-1:0] m;
        rst   = 1'b1;
        start = 1'b0;
        key   = '1;
        #22;
        check("reset leds", 32'(leds), 32'd0);
        check("reset round", 32'(round), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset win/over", 32'({win, over}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Abort in SHOW_ON, then replay from round 1
        do_start($urandom_range(1, 20));
        check("busy in SHOW_ON", 32'(busy), 32'd1);
        check("first colour lit", 32'(leds), 32'(1 << exp_seq[0]));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-game reset leds", 32'(leds), 32'd0);
        check("mid-game reset round", 32'(round), 32'd0);
        check("mid-game reset busy", 32'(busy), 32'd0);
        check("mid-game reset pulses", 32'({end_fpga, end_user, end_time, match, win, over}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full winning game
        do_start($urandom_range(1, 20));
        check("restart round 1", 32'(round), 32'd1);
        for (int r = 1; r <= int'(NL); r++) play_round(r);
        check("ten matches", 32'(n_match), 32'd10);
        check("win after last match", 32'(win), 32'd1);
        check("busy low in WIN", 32'(busy), 32'd0);
        @(negedge clk);
        check("leds all on in WIN", 32'(leds), 32'hF);
        check("round held in WIN", 32'(round), 32'(NL));

        // Wrong key first in round 2
        do_start($urandom_range(1, 20));
        check("START clears win", 32'(win), 32'd0);
        play_round(1);
        playback(2);
        m = '0;
        m[(exp_seq[0] + int'($urandom_range(1, 3))) % 4] = 1'b1;
        press(m);
        check("no match on wrong key", 32'(match), 32'd0);
        check("over on wrong key", 32'(over), 32'd1);
        check("busy low in LOSE", 32'(busy), 32'd0);
        check("round held in LOSE", 32'(round), 32'd2);

        // Timeout in round 1
        do_start($urandom_range(1, 20));
        check("START clears over", 32'(over), 32'd0);
        playback(1);
        early = 0;
        for (int k = 1; k < int'(NT); k++) begin
            @(negedge clk);
            if (end_time || over) early++;
        end
        check("no early timeout", 32'(early), 32'd0);
        @(negedge clk);
        check("end_time at cycle 20", 32'(end_time), 32'd1);
        check("over on timeout", 32'(over), 32'd1);
        @(negedge clk);
        check("end_time one cycle", 32'(end_time), 32'd0);
        check("over held", 32'(over), 32'd1);

        // Press during SHOW_ON ignored; two keys at once in WAIT_USER loses
        do_start($urandom_range(1, 20));
        m = '0;
        m[$urandom_range(0, 3)] = 1'b1;
        press(m);
        check("no match in SHOW_ON", 32'(match), 32'd0);
        check("still busy after SHOW_ON press", 32'(busy), 32'd1);
        w = 0;
        while (!end_fpga && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("end_FPGA after ignored press", 32'(end_fpga), 32'd1);
        a = int'($urandom_range(0, 3));
        b = (a + int'($urandom_range(1, 3))) % 4;
        m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        press(m);
        check("no match on double press", 32'(match), 32'd0);
        check("over on double press", 32'(over), 32'd1);

`ifdef GENIUS_BEST_SCORE_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("best cleared by reset", 32'(best), 32'd0);
        do_start($urandom_range(1, 20));
        play_round(1);
        play_round(2);
        playback(3);
        w = 0;
        while (!over && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("lost in round 3", 32'(over), 32'd1);
        check("best after round 3 loss", 32'(best), 32'd2);
        do_start($urandom_range(1, 20));
        check("best kept by START", 32'(best), 32'd2);
        playback(1);
        m = '0;
        m[(exp_seq[0] + 1) % 4] = 1'b1;
        press(m);
        check("lost in round 1", 32'(over), 32'd1);
        check("best after round 1 loss", 32'(best), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/genius_datapath_param.md
Name: genius_datapath_param

Overview:
- Parametrised, self-sequenced Genius (Simon) game datapath for the DE-series board.
- Generates a pseudo-random colour sequence, plays it back on the LEDs, checks the player's key presses and enforces a per-press time limit.
- Grows the sequence by one entry per round until P_LEVELS is reached (win), or a wrong key or timeout ends the game (lose).
- Replaces the externally enabled datapath/counterTime pair: internal FSM, configurable colour count, depth and timing.

Parameters:
- P_COLORS, 4, number of keys/LEDs; power of two, 2..8.
- P_LEVELS, 16, maximum sequence length (rounds to win), 2..64.
- P_SHOW, 25_000_000, CLOCK_50 cycles an LED stays on during playback.
- P_GAP, 12_500_000, CLOCK_50 cycles of all-LEDs-off between playback entries.
- P_TIMEOUT, 250_000_000, CLOCK_50 cycles allowed per player press.
- P_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- CLOCK_50  in  1  system clock.
- R  in  1  asynchronous active-high reset.
- START  in  1  one-cycle start pulse, from the controller.
- KEY  in  P_COLORS  player keys, active-low, asynchronous to CLOCK_50.
- leds  out  P_COLORS  one-hot LED drive, active-high.
- round  out  $clog2(P_LEVELS+1)  current round, 1..P_LEVELS; 0 in IDLE.
- end_FPGA  out  1  one-cycle pulse when playback of the round ends.
- end_User  out  1  one-cycle pulse when the player completes the round correctly.
- end_time  out  1  one-cycle pulse on timeout.
- match  out  1  one-cycle pulse per correct press.
- win  out  1  held high in WIN.
- over  out  1  held high in LOSE.
- busy  out  1  high in every state except IDLE, WIN and LOSE.

Behaviour:
- Reset (R=1, async): state IDLE; every output 0; LFSR=P_SEED; all counters 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including in IDLE, so the sequence depends on START timing.
- KEY handling:
  - KEY passes through a 2-flop synchroniser, then an edge register.
  - A press event is sync=0 with the previous sample=1, on any bit.
  - If more than one bit falls in the same cycle, or another key is already held, the event counts as a wrong press.
- States: IDLE, LOAD, SHOW_ON, SHOW_OFF, WAIT_USER, WIN, LOSE.
- IDLE/WIN/LOSE + START: go to LOAD; clear win and over; set round=1.
- START in any other state is ignored.
- LOAD:
  - Lasts P_LEVELS cycles.
  - Writes seq[i] = LFSR[$clog2(P_COLORS)-1:0], i=0..P_LEVELS-1, one entry per cycle.
  - Then go to SHOW_ON with idx=0.
- SHOW_ON:
  - leds = onehot(seq[idx]) for P_SHOW cycles, then go to SHOW_OFF.
  - Key events in this state are ignored.
- SHOW_OFF:
  - leds=0 for P_GAP cycles, then idx++.
  - If idx reaches round: pulse end_FPGA, set idx=0, clear the timeout counter, go to WAIT_USER. Otherwise go to SHOW_ON.
- WAIT_USER:
  - leds mirror the synchronised, inverted KEY.
  - Correct press (key == seq[idx]): pulse match, set idx++, restart the timeout counter.
  - If idx+1 == round on a correct press: pulse end_User.
    - If round == P_LEVELS: go to WIN.
    - Otherwise: round++, idx=0, go to SHOW_ON.
  - Wrong press: go to LOSE; no match pulse.
  - Timeout counter reaching P_TIMEOUT-1 with no press: pulse end_time, go to LOSE.
  - A press and a timeout in the same cycle: the press wins.
- match latency: match registers on the 3rd rising edge after the first edge that samples KEY low.
- WIN: win=1, leds all on. LOSE: over=1, leds=0. round holds its last value in both states.
- Key release never generates an event. A held key generates exactly one event.
- R asserted mid-game aborts immediately to the reset state. The sequence contents need no clearing.

Optional Feature:
- Macro GENIUS_BEST_SCORE_EN.
- When defined:
  - Adds output best [$clog2(P_LEVELS+1)] holding the highest completed round count of any game.
  - best updates on end_User when round > best.
  - best is cleared only by R; START does not clear it.
- When undefined: the port and its register are absent; behaviour is otherwise identical.

Test Plan (P_COLORS=4, P_LEVELS=4, P_SHOW=4, P_GAP=2, P_TIMEOUT=20):
- Reset mid-SHOW_ON -> all outputs 0 immediately, round=0, state IDLE; next START replays from round 1.
- START, record leds during playback, echo each colour with a 1-cycle-low KEY pulse -> per round: end_FPGA once, match once per press, end_User once; round goes 1→4; win=1 after the 10th match.
- Round 2, press a wrong key first -> no match pulse, over=1, busy=0, round stays 2.
- Round 1, no press for 20 cycles after end_FPGA -> end_time pulse at cycle 20, then over=1.
- Press during SHOW_ON, and press two keys simultaneously in WAIT_USER -> the first is ignored (no match, state unaffected); the second gives over=1.
- With GENIUS_BEST_SCORE_EN: reach round 3, then lose; START; lose in round 1 -> best=2, unchanged by the second START.
